// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the CPU control FSM: ALU opcodes, state encoding,
// opcode classes, datapath select encodings and trap causes.
package cpu_control_fsm_pkg;

  // ALU opcode definitions shared with the datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // FSM state encoding
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Instruction classes
  localparam logic [2:0] CLS_LUI     = 3'd0;
  localparam logic [2:0] CLS_AUIPC   = 3'd1;
  localparam logic [2:0] CLS_OP      = 3'd2;
  localparam logic [2:0] CLS_OP_IMM  = 3'd3;
  localparam logic [2:0] CLS_LOAD    = 3'd4;
  localparam logic [2:0] CLS_STORE   = 3'd5;
  localparam logic [2:0] CLS_JAL     = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  // Datapath select encodings
  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic       SRC_B_RS2  = 1'b0;
  localparam logic       SRC_B_IMM  = 1'b1;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  // ALU control word registered on entry to EXECUTE
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] src_a;
    logic       src_b;
  } ctrl_word_t;

  // Map a major opcode onto an instruction class
  function automatic logic [2:0] classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_OP:     return CLS_OP;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_JAL:    return CLS_JAL;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction/data memory handshake bundle between the control FSM and memory.
interface cpu_control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/cpu_control_fsm_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory handshake and flags the
// cycle in which the budget is exhausted without ready arriving.
module mem_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_TIMEOUT - 1);

  logic [7:0] r_count;

  // Timeout fires on the WAIT_TIMEOUT-th consecutive not-ready cycle
  assign o_timeout = i_wait && (r_count == LIMIT);

  // Wait counter: cleared on reset or any state change, else counts waits
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_wait) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshake timeouts, trap handling and retired-instruction count.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_control_fsm_if.master       bus,
  input  logic [31:0]             instruction,
  input  logic [2:0]              alu_op_dec,
  output logic                    ir_we,
  output logic [2:0]              alu_op,
  output logic [1:0]              alu_src_a,
  output logic                    alu_src_b,
  output logic [1:0]              wb_sel,
  output logic                    reg_we,
  output logic                    pc_we,
  output logic                    pc_sel,
  output logic                    halt,
  output logic [1:0]              trap_cause,
  output logic [31:0]             retired
);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [2:0]  r_cls;
  logic [2:0]  w_dec_cls;
  ctrl_word_t  r_ctrl;
  ctrl_word_t  w_ctrl;
  logic [1:0]  r_trap_cause;
  logic [1:0]  w_trap_cause;
  logic [31:0] r_retired;
  logic        w_wait;
  logic        w_timeout;
  logic        w_clear;
  logic        w_unused_instr;

  // Only the major opcode is interpreted here; the datapath decodes the rest
  assign w_unused_instr = ^instruction[31:7];
  assign w_dec_cls      = classify(instruction[6:0]);

  assign w_wait  = ((r_state == S_FETCH) && !bus.imem_ready) ||
                   ((r_state == S_MEM)   && !bus.dmem_ready);
  assign w_clear = (w_next_state != r_state);

  mem_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_wait    (w_wait),
    .o_timeout (w_timeout)
  );

  // Next-state and trap-cause selection
  always_comb begin
    w_next_state = r_state;
    w_trap_cause = TRAP_NONE;
    case (r_state)
      S_FETCH: begin
        if (bus.imem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_trap_cause = TRAP_IMEM;
        end
      end
      S_DECODE: begin
        if (w_dec_cls == CLS_ILLEGAL) begin
          w_next_state = S_TRAP;
          w_trap_cause = TRAP_ILLEGAL;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if ((r_cls == CLS_LOAD) || (r_cls == CLS_STORE)) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          w_next_state = (r_cls == CLS_STORE) ? S_FETCH : S_WRITEBACK;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_trap_cause = TRAP_DMEM;
        end
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_TRAP:      w_next_state = S_TRAP;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // ALU control word for the decoded instruction class
  always_comb begin
    w_ctrl = '0;
    case (w_dec_cls)
      CLS_LUI:    w_ctrl = '{alu_op: ALU_ADD,    src_a: SRC_A_ZERO, src_b: SRC_B_IMM};
      CLS_AUIPC:  w_ctrl = '{alu_op: ALU_ADD,    src_a: SRC_A_PC,   src_b: SRC_B_IMM};
      CLS_OP:     w_ctrl = '{alu_op: alu_op_dec, src_a: SRC_A_RS1,  src_b: SRC_B_RS2};
      CLS_OP_IMM: w_ctrl = '{alu_op: alu_op_dec, src_a: SRC_A_RS1,  src_b: SRC_B_IMM};
      CLS_LOAD,
      CLS_STORE:  w_ctrl = '{alu_op: ALU_ADD,    src_a: SRC_A_RS1,  src_b: SRC_B_IMM};
      CLS_JAL:    w_ctrl = '{alu_op: ALU_ADD,    src_a: SRC_A_PC,   src_b: SRC_B_IMM};
      default:    w_ctrl = '0;
    endcase
  end

  // Moore / handshake-qualified strobes of the current state
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    wb_sel       = WB_ALU;
    case (r_state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        ir_we        = bus.imem_ready;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (r_cls == CLS_STORE);
        pc_we        = (r_cls == CLS_STORE) && bus.dmem_ready;
      end
      S_WRITEBACK: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = (r_cls == CLS_JAL);
        if (r_cls == CLS_LOAD) begin
          wb_sel = WB_MEM;
        end else if (r_cls == CLS_JAL) begin
          wb_sel = WB_PC4;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction class and ALU control word, captured leaving DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls  <= CLS_LUI;
      r_ctrl <= '0;
    end else if ((r_state == S_DECODE) && (w_dec_cls != CLS_ILLEGAL)) begin
      r_cls  <= w_dec_cls;
      r_ctrl <= w_ctrl;
    end
  end

  // Trap cause latched on the transition into TRAP and held there
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_cause <= TRAP_NONE;
    end else if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
      r_trap_cause <= w_trap_cause;
    end
  end

  // Retired-instruction counter, one per PC update, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (pc_we) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign alu_op     = r_ctrl.alu_op;
  assign alu_src_a  = r_ctrl.src_a;
  assign alu_src_b  = r_ctrl.src_b;
  assign halt       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed testbench for cpu_control_fsm (WAIT_TIMEOUT = 4).
module tb_cpu_control_fsm;
  import cpu_control_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic [2:0]  alu_op_dec = 3'b000;
  logic        ir_we, alu_src_b, reg_we, pc_we, pc_sel, halt;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src_a, wb_sel, trap_cause;
  logic [31:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [5:0]  exp_ctrl = 6'd0;

  always #5 clk = ~clk;

  cpu_control_fsm_if u_bus ();

  cpu_control_fsm #(
    .WAIT_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_bus),
    .instruction(instruction),
    .alu_op_dec (alu_op_dec),
    .ir_we      (ir_we),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .wb_sel     (wb_sel),
    .reg_we     (reg_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .halt       (halt),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    u_bus.imem_ready = 1'b0;
    u_bus.dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_retired = 32'd0;
    exp_ctrl = 6'd0;
  endtask

  // Four-cycle non-memory instruction starting in FETCH with zero-wait imem
  task automatic run_alu(input string tag, input logic [31:0] instr, input logic [2:0] dec,
                         input logic [1:0] a, input logic b, input logic [2:0] op,
                         input logic [1:0] wb, input logic psel);
    instruction = instr;
    alu_op_dec = dec;
    u_bus.imem_ready = 1'b1;
    #1;
    check_eq({tag, "/fetch"}, {u_bus.imem_req, ir_we}, 32'b11);
    tick();
    check_eq({tag, "/decode_strobes"}, {u_bus.imem_req, reg_we, pc_we}, 32'b000);
    check_eq({tag, "/decode_hold"}, {alu_op, alu_src_a, alu_src_b}, exp_ctrl);
    tick();
    exp_ctrl = {op, a, b};
    check_eq({tag, "/exec_ctrl"}, {alu_op, alu_src_a, alu_src_b}, exp_ctrl);
    check_eq({tag, "/exec_strobes"}, {reg_we, pc_we}, 32'b00);
    tick();
    check_eq({tag, "/wb"}, {reg_we, pc_we, pc_sel, wb_sel}, {27'd0, 1'b1, 1'b1, psel, wb});
    exp_retired = exp_retired + 32'd1;
    tick();
    check_eq({tag, "/retired"}, retired, exp_retired);
  endtask

  initial begin
    u_bus.imem_ready = 1'b0;
    u_bus.dmem_ready = 1'b0;
    do_reset();

    // Reset state, first cycle out of reset
    check_eq("rst/imem_req", u_bus.imem_req, 32'd1);
    check_eq("rst/halt_cause", {halt, trap_cause}, 32'd0);
    check_eq("rst/retired", retired, 32'd0);

    run_alu("lui",   32'hABCDE2B7, 3'b101, SRC_A_ZERO, SRC_B_IMM, ALU_ADD, WB_ALU, 1'b0);
    run_alu("auipc", 32'h12345397, 3'b101, SRC_A_PC,   SRC_B_IMM, ALU_ADD, WB_ALU, 1'b0);
    run_alu("op",    32'h003100B3, 3'b110, SRC_A_RS1,  SRC_B_RS2, 3'b110,  WB_ALU, 1'b0);
    run_alu("opimm", 32'h00A00093, 3'b011, SRC_A_RS1,  SRC_B_IMM, 3'b011,  WB_ALU, 1'b0);
    run_alu("jal",   32'h008000EF, 3'b111, SRC_A_PC,   SRC_B_IMM, ALU_ADD, WB_PC4, 1'b1);

    // Zero-wait store: retires in MEM, cycle 4
    instruction = 32'h0062A023;
    alu_op_dec = 3'b111;
    u_bus.dmem_ready = 1'b1;
    tick();
    tick();
    check_eq("sw/exec_ctrl", {alu_op, alu_src_a, alu_src_b}, {26'd0, ALU_ADD, SRC_A_RS1, SRC_B_IMM});
    tick();
    check_eq("sw/mem", {u_bus.dmem_req, u_bus.dmem_we, pc_we, pc_sel, reg_we}, 32'b11100);
    exp_retired = exp_retired + 32'd1;
    tick();
    check_eq("sw/retired", retired, exp_retired);
    check_eq("sw/next_fetch", u_bus.imem_req, 32'd1);

    // Load with dmem ready on the 4th MEM cycle (boundary: count reaches limit)
    instruction = 32'h0002A303;
    u_bus.dmem_ready = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) u_bus.dmem_ready = 1'b1;
      #1;
      check_eq($sformatf("lw/mem%0d", i), {u_bus.dmem_req, u_bus.dmem_we, reg_we, halt}, 32'b1000);
      tick();
    end
    u_bus.dmem_ready = 1'b0;
    check_eq("lw/wb_c8", {reg_we, pc_we, wb_sel, u_bus.dmem_req, halt}, 32'b110100);
    exp_retired = exp_retired + 32'd1;
    tick();
    check_eq("lw/retired", retired, exp_retired);

    // Reset during MEM of a store, with ready asserted in the same cycle
    instruction = 32'h0062A023;
    tick();
    tick();
    tick();
    check_eq("swrst/in_mem", u_bus.dmem_req, 32'd1);
    rst = 1'b1;
    u_bus.dmem_ready = 1'b1;
    tick();
    rst = 1'b0;
    u_bus.dmem_ready = 1'b0;
    u_bus.imem_ready = 1'b0;
    #1;
    check_eq("swrst/fetch", {u_bus.imem_req, u_bus.dmem_req}, 32'b10);
    check_eq("swrst/retired", retired, 32'd0);
    check_eq("swrst/ctrl", {alu_op, alu_src_a, alu_src_b}, 32'd0);

    // imem never ready: trap cause 10 after 4 cycles
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("imto/wait%0d", i), {u_bus.imem_req, halt}, 32'b10);
      tick();
    end
    check_eq("imto/trap", {halt, trap_cause, u_bus.imem_req}, 32'b1100);

    // imem ready on the 4th cycle wins over the timeout
    do_reset();
    instruction = 32'hABCDE2B7;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) u_bus.imem_ready = 1'b1;
      #1;
      check_eq($sformatf("imok/wait%0d", i), {u_bus.imem_req, halt}, 32'b10);
      tick();
    end
    check_eq("imok/decode", {halt, u_bus.imem_req, trap_cause}, 32'b0000);

    // dmem never ready: trap cause 11
    do_reset();
    instruction = 32'h0002A303;
    u_bus.imem_ready = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    check_eq("dmto/trap", {halt, trap_cause, u_bus.dmem_req}, 32'b1110);

    // Illegal opcode: trap cause 01 from cycle 3, held, cleared by reset
    do_reset();
    instruction = 32'h0000007F;
    u_bus.imem_ready = 1'b1;
    u_bus.dmem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("ill/held%0d", i),
               {halt, trap_cause, u_bus.imem_req, ir_we, u_bus.dmem_req, reg_we, pc_we}, 32'b10100000);
      tick();
    end
    check_eq("ill/retired", retired, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("ill/recover", {halt, trap_cause, u_bus.imem_req}, 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 16: consecutive not-ready cycles on a memory handshake before trapping; range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instruction  input  32  instruction register contents (valid from DECODE onward).
REQ-005 alu_op_dec  input  3  ALU opcode from the R/I-type decoder.
REQ-006 imem_ready  input  1  instruction memory returned data this cycle.
REQ-007 dmem_ready  input  1  data memory completed the access this cycle.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_we  output  1  latch instruction register.
REQ-010 dmem_req, dmem_we  output  1 each  data access request; store when dmem_we=1.
REQ-011 alu_op  output  3  ALU opcode; ALU_ADD per the shared ALU opcode definitions.
REQ-012 alu_src_a  output  2  00 RS1, 01 PC, 10 ZERO.
REQ-013 alu_src_b  output  1  0 RS2, 1 IMM.
REQ-014 wb_sel  output  2  00 ALU, 01 MEM, 10 PC4.
REQ-015 reg_we, pc_we, pc_sel  output  1 each  register write, PC write, PC source (0 PC+4, 1 ALU result).
REQ-016 halt  output  1  core stopped; trap_cause  output  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.
REQ-017 retired  output  32  retired-instruction count.

Function
REQ-018 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; strobes (imem_req, ir_we, dmem_req, reg_we, pc_we) are Moore/handshake-qualified combinational outputs of the current state.
REQ-019 FETCH: imem_req=1; if imem_ready, ir_we=1 that cycle and next state DECODE; else stay, wait counter +1.
REQ-020 DECODE: classify instruction[6:0]: 0110111 LUI, 0010111 AUIPC, 0110011 OP, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1101111 JAL; any other opcode -> TRAP with cause 01; else -> EXECUTE.
REQ-021 EXECUTE: register control word: LUI ZERO/IMM/ADD; AUIPC PC/IMM/ADD; OP RS1/RS2/alu_op_dec; OP-IMM RS1/IMM/alu_op_dec; LOAD, STORE RS1/IMM/ADD; JAL PC/IMM/ADD. Next: LOAD/STORE -> MEM, others -> WRITEBACK.
REQ-022 Registered alu_op/alu_src_a/alu_src_b hold from EXECUTE until the next EXECUTE.
REQ-023 MEM: dmem_req=1, dmem_we=1 iff STORE; on dmem_ready: STORE -> pc_we=1, pc_sel=0, retire, -> FETCH; LOAD -> WRITEBACK; else stay, wait counter +1.
REQ-024 WRITEBACK: reg_we=1, pc_we=1; wb_sel MEM for LOAD, PC4 for JAL, ALU otherwise; pc_sel=1 only for JAL; retire; -> FETCH.
REQ-025 Latency with zero-wait memory: LUI/AUIPC/OP/OP-IMM/JAL 4 cycles, STORE 4, LOAD 5.
REQ-026 Wait counter clears on every state change; reaching WAIT_TIMEOUT in FETCH -> TRAP cause 10, in MEM -> TRAP cause 11; ready arriving in the same cycle the count reaches WAIT_TIMEOUT wins (no trap).
REQ-027 retired increments by 1 per retirement (pc_we=1), wraps 0xFFFFFFFF -> 0.
REQ-028 TRAP: halt=1, all strobes 0, trap_cause held; left only by rst.

Reset
REQ-029 rst high at a clock edge: state FETCH, wait counter 0, retired 0, trap_cause 00, halt 0, registered control word 0 (alu_op 0, sources 00/0); takes priority over any in-flight handshake, including mid-MEM.
REQ-030 First cycle after rst deasserts asserts imem_req=1.

Structure
REQ-031 State encoding, opcode constants, alu_src/wb_sel/trap_cause encodings go in the shared package alongside the existing ALU opcode definitions.
REQ-032 One sub-module, mem_wait_timer (counter + timeout flag), shared by FETCH and MEM.

Verification
REQ-033 instruction 0xABCDE2B7 (lui x5), imem_ready=1 -> alu_src_a=10, alu_src_b=1, alu_op=ALU_ADD; reg_we=1, wb_sel=00 in cycle 4; retired=1.
REQ-034 instruction 0x12345397 (auipc x7) -> alu_src_a=01, alu_op=ALU_ADD, reg_we in cycle 4.
REQ-035 instruction 0x0000007F -> halt=1, trap_cause=01 from cycle 3; stays halted 20 cycles; rst recovers to FETCH.
REQ-036 WAIT_TIMEOUT=4, imem_ready held 0 -> TRAP cause 10 after 4 cycles; repeat with ready on 4th cycle -> no trap.
REQ-037 LOAD 0x0002A303, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, wb_sel=01, reg_we in cycle 8.
REQ-038 rst pulsed during MEM of a STORE -> next cycle FETCH, dmem_req=0, retired=0.
